// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-requester RAM arbiter.
// The round-robin tie-break is selected by defining RAM_ARB_RR_EN.
package ram_arb_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes and RAM macro signals around ram_arbiter.
// slave is the arbiter's view; master is the clients-plus-RAM view.
interface ram_arbiter_if #(
   parameter int ADDR_W = ram_arb_pkg::ADDR_W,
   parameter int DATA_W = ram_arb_pkg::DATA_W
);

   logic              req_a;
   logic              req_b;
   logic              we_a;
   logic              we_b;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] wdata_a;
   logic [DATA_W-1:0] wdata_b;
   logic              ack_a;
   logic              ack_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic              busy;

   logic              ram_ena;
   logic              ram_wena;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
      input  ram_rdata,
      output ack_a, ack_b, rdata_a, rdata_b, busy,
      output ram_ena, ram_wena, ram_addr, ram_wdata
   );

   modport master (
      output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
      output ram_rdata,
      input  ack_a, ack_b, rdata_a, rdata_b, busy,
      input  ram_ena, ram_wena, ram_addr, ram_wdata
   );

endinterface

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational two-way grant. RAM_ARB_RR_EN: ties go to the requester that
// was not served last; otherwise A always wins a tie.
module arb_pick
   import ram_arb_pkg::*;
(
   input  logic   req_a,
   input  logic   req_b,
`ifdef RAM_ARB_RR_EN
   input  owner_e last_owner,
`endif
   output logic   grant,
   output owner_e owner
);

   always_comb begin
      grant = req_a | req_b;
      owner = OWN_A;
      if (req_a && req_b) begin
`ifdef RAM_ARB_RR_EN
         owner = (last_owner == OWN_A) ? OWN_B : OWN_A;
`else
         owner = OWN_A;
`endif
      end else if (req_b) begin
         owner = OWN_B;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between requesters A and B: IDLE -> ACCESS -> DONE.
// Define RAM_ARB_RR_EN for round-robin tie-breaking (fixed A priority otherwise).
module ram_arbiter #(
   parameter int ADDR_W = ram_arb_pkg::ADDR_W,
   parameter int DATA_W = ram_arb_pkg::DATA_W
) (
   input logic          clk,
   input logic          rst,
   ram_arbiter_if.slave bus
);

   import ram_arb_pkg::*;

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

   logic              grant;
   owner_e            grant_owner;

`ifdef RAM_ARB_RR_EN
   owner_e            last_owner_q, last_owner_d;
`endif

   arb_pick u_pick (
      .req_a      (bus.req_a),
      .req_b      (bus.req_b),
`ifdef RAM_ARB_RR_EN
      .last_owner (last_owner_q),
`endif
      .grant      (grant),
      .owner      (grant_owner)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
`ifdef RAM_ARB_RR_EN
      last_owner_d = last_owner_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant) begin
               owner_d = grant_owner;
               if (grant_owner == OWN_A) begin
                  we_d    = bus.we_a;
                  addr_d  = bus.addr_a;
                  wdata_d = bus.wdata_a;
               end else begin
                  we_d    = bus.we_b;
                  addr_d  = bus.addr_b;
                  wdata_d = bus.wdata_b;
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // ram_rdata is only meaningful here, on a read cycle
            if (!we_q) begin
               if (owner_q == OWN_A) begin
                  rdata_a_d = bus.ram_rdata;
               end else begin
                  rdata_b_d = bus.ram_rdata;
               end
            end
            state_d = DONE;
         end
         DONE: begin
`ifdef RAM_ARB_RR_EN
            last_owner_d = owner_q;
`endif
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_A;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
`ifdef RAM_ARB_RR_EN
         last_owner_q <= OWN_B;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
`ifdef RAM_ARB_RR_EN
         last_owner_q <= last_owner_d;
`endif
      end
   end

   // Decoded from state so reset kills the RAM strobe without waiting for an edge
   logic in_access;
   logic in_done;

   assign in_access = (state_q == ACCESS);
   assign in_done   = (state_q == DONE);

   assign bus.ram_ena   = in_access;
   assign bus.ram_wena  = in_access & we_q;
   assign bus.ram_addr  = in_access ? addr_q  : '0;
   assign bus.ram_wdata = in_access ? wdata_q : '0;

   assign bus.ack_a   = in_done & (owner_q == OWN_A);
   assign bus.ack_b   = in_done & (owner_q == OWN_B);
   assign bus.busy    = (state_q != IDLE);
   assign bus.rdata_a = rdata_a_q;
   assign bus.rdata_b = rdata_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level model plus directed tests.
module tb_ram_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_arbiter_if bus ();

   ram_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // RAM macro stand-in: preset contents, synchronous write, combinational read
   logic [31:0] ram [0:31];
   bit          ram_init = 1'b0;
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 32; i++) ram[i] = 32'h1000_0000 + 32'(i);
         ram_init = 1'b1;
      end else if (bus.ram_ena && bus.ram_wena) begin
         ram[bus.ram_addr] = bus.ram_wdata;
      end
   end
   assign bus.ram_rdata = (bus.ram_ena && !bus.ram_wena) ? ram[bus.ram_addr] : 'z;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ena_total = 0;
   always @(negedge clk) if (bus.ram_ena) ena_total <= ena_total + 1;

   // Transaction model: a grant starts a 3-cycle slot (access, ack, idle)
   logic [31:0] shadow [0:31];
   bit          sh_init = 1'b0;
   bit          m_active = 1'b0;
   int          m_age = 0;
`ifdef RAM_ARB_RR_EN
   bit          m_last = 1'b1;
`endif
   bit          t_own = 1'b0;
   bit          t_we = 1'b0;
   logic [4:0]  t_addr = '0;
   logic [31:0] t_wdata = '0;
   logic [31:0] m_rd_a = '0;
   logic [31:0] m_rd_b = '0;

   always @(posedge clk or posedge rst) begin
      if (!sh_init) begin
         for (int i = 0; i < 32; i++) shadow[i] = 32'h1000_0000 + 32'(i);
         sh_init = 1'b1;
      end
      if (rst) begin
         m_active = 1'b0;
         m_age    = 0;
`ifdef RAM_ARB_RR_EN
         m_last   = 1'b1;
`endif
         m_rd_a   = '0;
         m_rd_b   = '0;
      end else if (m_active) begin
         if (m_age == 1) begin
            if (t_we) shadow[t_addr] = t_wdata;
            else if (t_own) m_rd_b = shadow[t_addr];
            else m_rd_a = shadow[t_addr];
            m_age = 2;
         end else begin
            m_active = 1'b0;
`ifdef RAM_ARB_RR_EN
            m_last = t_own;
`endif
         end
      end else if (bus.req_a || bus.req_b) begin
         if (bus.req_a && bus.req_b) begin
`ifdef RAM_ARB_RR_EN
            t_own = !m_last;
`else
            t_own = 1'b0;
`endif
         end else begin
            t_own = bus.req_b;
         end
         t_we     = t_own ? bus.we_b    : bus.we_a;
         t_addr   = t_own ? bus.addr_b  : bus.addr_a;
         t_wdata  = t_own ? bus.wdata_b : bus.wdata_a;
         m_active = 1'b1;
         m_age    = 1;
      end
   end

   always @(negedge clk) begin
      logic e_ena;
      e_ena = m_active && (m_age == 1);
      chk("ram_ena",   32'(bus.ram_ena),  32'(e_ena));
      chk("ram_wena",  32'(bus.ram_wena), 32'(e_ena && t_we));
      chk("ram_addr",  32'(bus.ram_addr), e_ena ? 32'(t_addr) : 32'd0);
      chk("ram_wdata", bus.ram_wdata,     e_ena ? t_wdata : 32'd0);
      chk("ack_a", 32'(bus.ack_a), 32'(m_active && m_age == 2 && !t_own));
      chk("ack_b", 32'(bus.ack_b), 32'(m_active && m_age == 2 && t_own));
      chk("busy",  32'(bus.busy),  32'(m_active));
      chk("rdata_a", bus.rdata_a, m_rd_a);
      chk("rdata_b", bus.rdata_b, m_rd_b);
   end

   // Start at posedge+1; holds req until ack, drops it in the following cycle
   task automatic do_req(input bit side, input bit we, input logic [4:0] addr,
                         input logic [31:0] wd, output int ack_cyc, output int lat);
      bit seen;
      lat = 0;
      ack_cyc = -1;
      seen = 1'b0;
      if (side) begin
         bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd; bus.req_b = 1'b1;
      end else begin
         bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd; bus.req_a = 1'b1;
      end
      for (int n = 1; n <= 20 && !seen; n++) begin
         @(negedge clk);
         if ((side ? bus.ack_b : bus.ack_a) == 1'b1) begin
            seen = 1'b1;
            lat = n;
            ack_cyc = cyc;
         end
      end
      chk(side ? "ack_b_seen" : "ack_a_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      if (side) bus.req_b = 1'b0; else bus.req_a = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ca, cb, la, lb, e0, na, nb, acks_seen;
      bit alt_ok;
      bit seq[$];

      bus.req_a = 0; bus.req_b = 0; bus.we_a = 0; bus.we_b = 0;
      bus.addr_a = '0; bus.addr_b = '0; bus.wdata_a = '0; bus.wdata_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
      chk("rst_rdata_a", bus.rdata_a, 32'd0);
      chk("rst_rdata_b", bus.rdata_b, 32'd0);
      chk("rst_ram", 32'({bus.ram_ena, bus.ram_wena}) | 32'(bus.ram_addr) | bus.ram_wdata, 32'd0);
      @(posedge clk);
      #1;

      // A writes then reads back addr 3
      e0 = ena_total;
      do_req(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, ca, la);
      chk("wr_latency", 32'(la), 32'd3);
      chk("wr_ena_cycles", 32'(ena_total - e0), 32'd1);
      e0 = ena_total;
      do_req(1'b0, 1'b0, 5'd3, 32'd0, ca, la);
      chk("rd_latency", 32'(la), 32'd3);
      chk("rd_ena_cycles", 32'(ena_total - e0), 32'd1);
      chk("rd_a_addr3", bus.rdata_a, 32'hDEAD_BEEF);
      $display("txn A wr/rd addr3 rdata_a=%h", bus.rdata_a);

      // Simultaneous pair right after reset: A first, B three cycles later
      do_reset();
      fork
         do_req(1'b0, 1'b0, 5'd3, 32'd0, ca, la);
         do_req(1'b1, 1'b0, 5'd5, 32'd0, cb, lb);
      join
      chk("tie1_a_first", 32'(ca < cb), 32'd1);
      chk("tie1_gap", 32'(cb - ca), 32'd3);
      chk("tie1_rd_a", bus.rdata_a, 32'hDEAD_BEEF);
      chk("tie1_rd_b", bus.rdata_b, 32'h1000_0005);
      $display("txn tie1 ack_a@%0d ack_b@%0d", ca, cb);

      // A-only write, then a second simultaneous pair
      do_req(1'b0, 1'b1, 5'd10, 32'h0A0A_0A0A, ca, la);
      fork
         do_req(1'b0, 1'b0, 5'd10, 32'd0, ca, la);
         do_req(1'b1, 1'b0, 5'd3, 32'd0, cb, lb);
      join
`ifdef RAM_ARB_RR_EN
      chk("tie2_b_first", 32'(cb < ca), 32'd1);
      chk("tie2_gap", 32'(ca - cb), 32'd3);
`else
      chk("tie2_a_first", 32'(ca < cb), 32'd1);
      chk("tie2_gap", 32'(cb - ca), 32'd3);
`endif
      chk("tie2_rd_a", bus.rdata_a, 32'h0A0A_0A0A);
      chk("tie2_rd_b", bus.rdata_b, 32'hDEAD_BEEF);
      $display("txn tie2 ack_a@%0d ack_b@%0d", ca, cb);

      // Both requests held continuously for 24 cycles
      do_reset();
      bus.we_a = 0; bus.addr_a = 5'd1; bus.we_b = 0; bus.addr_b = 5'd2;
      bus.req_a = 1; bus.req_b = 1;
      na = 0; nb = 0;
      repeat (24) begin
         @(negedge clk);
         if (bus.ack_a) begin na++; seq.push_back(1'b0); end
         if (bus.ack_b) begin nb++; seq.push_back(1'b1); end
      end
      @(posedge clk);
      #1 bus.req_a = 0; bus.req_b = 0;
      repeat (2) @(posedge clk);
      #1;
`ifdef RAM_ARB_RR_EN
      alt_ok = (seq.size() > 0) && (seq[0] == 1'b0);
      for (int i = 1; i < seq.size(); i++) if (seq[i] == seq[i-1]) alt_ok = 1'b0;
      chk("rr_alternate", 32'(alt_ok), 32'd1);
      chk("rr_count_a", 32'(na), 32'd4);
      chk("rr_count_b", 32'(nb), 32'd4);
`else
      chk("fp_count_a", 32'(na), 32'd8);
      chk("fp_b_starved", 32'(nb), 32'd0);
`endif
      $display("txn continuous acks_a=%0d acks_b=%0d", na, nb);

      // B reads 31, A writes 31: neither rdata register is disturbed by the write
      do_req(1'b1, 1'b0, 5'd31, 32'd0, cb, lb);
      chk("b_rd31", bus.rdata_b, 32'h1000_001F);
      do_req(1'b0, 1'b1, 5'd31, 32'h0000_0001, ca, la);
      chk("b_rd31_kept", bus.rdata_b, 32'h1000_001F);
      chk("a_rd_kept", bus.rdata_a, 32'h1000_0001);
      do_req(1'b0, 1'b0, 5'd31, 32'd0, ca, la);
      chk("a_rd31", bus.rdata_a, 32'h0000_0001);
      $display("txn addr31 rdata_a=%h rdata_b=%h", bus.rdata_a, bus.rdata_b);

      // Reset lands in the middle of an ACCESS write of 0x55 to addr 7
      bus.we_a = 1; bus.addr_a = 5'd7; bus.wdata_a = 32'h55; bus.req_a = 1;
      @(posedge clk);
      #1 chk("pre_rst_ena", 32'(bus.ram_ena), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_ena", 32'(bus.ram_ena), 32'd0);
      chk("mid_rst_wena", 32'(bus.ram_wena), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_bus", 32'(bus.ram_addr) | bus.ram_wdata | 32'(bus.ack_a), 32'd0);
      bus.req_a = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      acks_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.ack_a || bus.ack_b) acks_seen++;
      end
      chk("mid_rst_no_ack", 32'(acks_seen), 32'd0);
      @(posedge clk);
      #1;
      do_req(1'b0, 1'b0, 5'd7, 32'd0, ca, la);
      chk("addr7_preserved", bus.rdata_a, 32'h1000_0007);
      $display("txn reset-mid-write addr7 rdata_a=%h", bus.rdata_a);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares one 32-word × 32-bit single-port RAM between two requesters, A and B. Each requester issues a read or write with a req/ack handshake. The arbiter picks a winner, drives the RAM control and address for exactly one cycle, captures read data, and acknowledges the requester. It sits between the RAM macro and two datapath clients, for example an instruction fetch unit and a load/store unit.

## Interface
Parameters:
- ADDR_W, 5, RAM address width (32 words)
- DATA_W, 32, RAM data width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_a / req_b  in  1  access request from A / B; held high until ack
- we_a / we_b  in  1  1 = write, 0 = read; stable while req is high
- addr_a / addr_b  in  ADDR_W  word address; stable while req is high
- wdata_a / wdata_b  in  DATA_W  write data; stable while req is high
- ack_a / ack_b  out  1  one-cycle completion pulse
- rdata_a / rdata_b  out  DATA_W  registered read data, valid from the ack cycle onward
- busy  out  1  high whenever the FSM is not in IDLE
- ram_ena  out  1  RAM enable
- ram_wena  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM combinational read data; high-Z when not reading, and only sampled in ACCESS

## Operation
FSM has three states: IDLE → ACCESS → DONE → IDLE.
- **IDLE:**
  - No request: stay in IDLE.
  - One request: latch that requester's we, addr and wdata plus an owner bit, then go to ACCESS.
  - Both requesting: the arbitration rule (see Configuration) picks the owner.
- **ACCESS (exactly one cycle):**
  - ram_ena = 1, ram_wena = latched we, ram_addr and ram_wdata from the latched registers.
  - Writes commit in the RAM at the closing edge.
  - For reads, ram_rdata is captured into the owner's rdata register at the closing edge.
  - Always go to DONE.
- **DONE:**
  - Drive ack of the owner to 1 for this cycle only, then go to IDLE.
  - Update last_owner = owner.
- **RAM outputs outside ACCESS:**
  - ram_ena = 0, ram_wena = 0, ram_addr = 0, ram_wdata = 0.
  - The RAM is never enabled in any other state.
- **Read data retention:**
  - rdata_x holds its value until the next read completes for that same requester.
  - Writes never modify rdata_x.
- **Requester obligations:**
  - Drop req in the cycle after ack.
  - A req still high in IDLE after its ack is treated as a new request.
- **Non-owner requests:** requests arriving while busy wait; they are not lost and never preempt the current access.

## Timing
- **Reset values:** state IDLE, last_owner = B, owner = A, latched registers 0, ack_a = ack_b = 0, rdata_a = rdata_b = 0, busy = 0, all ram_* outputs 0.
- **Latency:**
  - req sampled at edge N, ACCESS in cycle N..N+1, ack high in cycle N+1..N+2.
  - Read data valid together with ack.
  - Peak throughput: one access per 3 cycles.
- **Reset mid-operation:**
  - ram_ena and ram_wena drop asynchronously, so no write commits at the next edge.
  - An in-flight access is lost and no ack is issued; the requester re-requests.
- ack_a and ack_b are never high in the same cycle.

## Configuration
Macro: RAM_ARB_RR_EN.
- **Defined:** round-robin. On simultaneous req_a and req_b, grant the requester that is not last_owner. With last_owner = B at reset, A wins the first tie.
- **Undefined:** fixed priority. A always wins ties, last_owner is not implemented, and B can starve under continuous A traffic.

## Structure
- **Package ram_arb_pkg:**
  - ADDR_W / DATA_W constants
  - state enum typedef (IDLE, ACCESS, DONE)
  - owner typedef (OWN_A, OWN_B)
- **Sub-module arb_pick:**
  - Combinational 2-way grant selection from req_a, req_b and last_owner.
  - Contains both the round-robin and the fixed-priority variant under RAM_ARB_RR_EN.

## Test plan
- A writes 0xDEADBEEF to addr 3, then reads addr 3:
  - ram_ena high exactly 1 cycle per access.
  - ack_a pulses 2 cycles after req sampled.
  - rdata_a = 0xDEADBEEF.
- A and B both request on the same edge after reset:
  - A granted first; B acked 3 cycles later.
  - With RAM_ARB_RR_EN, a second simultaneous pair is served B first.
- Continuous req_a plus req_b held:
  - Round-robin: strict A/B alternation.
  - Fixed priority: B never acked over 20 cycles.
- B reads addr 31, then A writes addr 31 = 0x1:
  - rdata_b is unchanged by A's write.
  - rdata_a is unchanged by the write.
- rst asserted during an ACCESS write of 0x55 to addr 7:
  - All outputs return to 0 immediately and no ack is issued.
  - A later read of addr 7 does not return 0x55 (prior contents preserved).
